display_frame_streamer: RTL and testbench

DISPLAY_FRAME_STREAMER -- requirements
Module: display_frame_streamer

---
 rtl/display_stream_pkg.sv | 28 ++
 rtl/display_beat_counter.sv | 71 +++++++
 rtl/display_frame_streamer.sv | 148 ++++++++++++++
 tb/tb_display_frame_streamer.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_stream_pkg.sv
// Shared state encoding and beat-geometry helpers for the display frame streamer.
package display_stream_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } stream_state_e;

    function automatic int beats_per_row(input int disp_w, input int beat_w);
        return disp_w / beat_w;
    endfunction

    function automatic int total_beats(input int disp_w, input int disp_h, input int beat_w);
        return disp_h * (disp_w / beat_w);
    endfunction

    function automatic int beat_idx_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    localparam int DEFAULT_DISP_W = 64;
    localparam int DEFAULT_DISP_H = 32;
    localparam int DEFAULT_BEAT_W = 8;
    localparam int BEATS_PER_ROW  = beats_per_row(DEFAULT_DISP_W, DEFAULT_BEAT_W);
    localparam int TOTAL_BEATS    = total_beats(DEFAULT_DISP_W, DEFAULT_DISP_H, DEFAULT_BEAT_W);
    localparam int BEAT_IDX_W     = beat_idx_width(TOTAL_BEATS);

endpackage

// File: rtl/display_beat_counter.sv
// Tracks beat index and row position; flags are registered so they line up with the beat they describe.
module display_beat_counter
    import display_stream_pkg::*;
#(
    parameter int TOTAL = TOTAL_BEATS,
    parameter int BPR   = BEATS_PER_ROW,
    parameter int IDX_W = BEAT_IDX_W
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic advance,
    output logic first_beat,
    output logic last_of_row,
    output logic last_of_frame
);

    localparam int COL_W = (BPR > 1) ? $clog2(BPR) : 1;

    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_next_s;
    logic [COL_W-1:0] col_r;
    logic [COL_W-1:0] col_next_s;
    logic             first_r;
    logic             last_row_r;
    logic             last_frame_r;

    // Next beat / column position, wrapping at frame and row boundaries
    always_comb begin
        idx_next_s = '0;
        col_next_s = '0;
        if (last_frame_r) begin
            idx_next_s = '0;
        end else begin
            idx_next_s = idx_r + IDX_W'(1);
        end
        if (last_row_r) begin
            col_next_s = '0;
        end else begin
            col_next_s = col_r + COL_W'(1);
        end
    end

    // Position and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r        <= '0;
            col_r        <= '0;
            first_r      <= 1'b0;
            last_row_r   <= 1'b0;
            last_frame_r <= 1'b0;
        end else if (load) begin
            idx_r        <= '0;
            col_r        <= '0;
            first_r      <= 1'b1;
            last_row_r   <= (BPR == 1);
            last_frame_r <= (TOTAL == 1);
        end else if (advance) begin
            idx_r        <= idx_next_s;
            col_r        <= col_next_s;
            first_r      <= (idx_next_s == '0);
            last_row_r   <= (col_next_s == COL_W'(BPR - 1));
            last_frame_r <= (idx_next_s == IDX_W'(TOTAL - 1));
        end
    end

    assign first_beat    = first_r;
    assign last_of_row   = last_row_r;
    assign last_of_frame = last_frame_r;

endmodule

// File: rtl/display_frame_streamer.sv
// Captures a framebuffer snapshot on frame_tick and streams it out as ready/valid beats.
module display_frame_streamer
    import display_stream_pkg::*;
#(
    parameter int DISP_W = 64,
    parameter int DISP_H = 32,
    parameter int BEAT_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DISP_W*DISP_H-1:0] display,
    input  logic                     frame_tick,
    input  logic                     change_only,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [BEAT_W-1:0]        out_data,
    output logic                     out_sof,
    output logic                     out_eol,
    output logic                     out_eof,
    output logic                     busy,
    output logic [CNT_W-1:0]         frame_count,
    output logic [7:0]               drop_count
);

    localparam int PIX_N = DISP_W * DISP_H;
    localparam int BPR   = beats_per_row(DISP_W, BEAT_W);
    localparam int TOTAL = total_beats(DISP_W, DISP_H, BEAT_W);
    localparam int IDX_W = beat_idx_width(TOTAL);

    stream_state_e    state_r;
    stream_state_e    state_next_s;
    logic [PIX_N-1:0] snap_r;
    logic [PIX_N-1:0] snap_rot_s;
    logic [PIX_N-1:0] last_frame_r;
    logic [CNT_W-1:0] frame_count_r;
    logic [7:0]       drop_count_r;
    logic             same_frame_s;
    logic             accept_s;
    logic             xfer_s;
    logic             drop_s;
    logic             finish_s;
    logic             first_beat_s;
    logic             last_of_row_s;
    logic             last_of_frame_s;

    assign same_frame_s = (display == last_frame_r);
    // The snapshot rotates one beat per transfer, so after a full frame it is back to the original image.
    assign snap_rot_s   = (snap_r << BEAT_W) | (snap_r >> (PIX_N - BEAT_W));
    assign finish_s     = xfer_s && last_of_frame_s;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_tick && !(change_only && same_frame_s)) begin
                    state_next_s = ST_STREAM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (out_ready && last_of_frame_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_STREAM;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Per-state control strobes
    always_comb begin
        accept_s = 1'b0;
        xfer_s   = 1'b0;
        drop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                accept_s = frame_tick && !(change_only && same_frame_s);
            end
            ST_STREAM: begin
                xfer_s = out_ready;
                drop_s = frame_tick;
            end
            default: begin
                accept_s = 1'b0;
            end
        endcase
    end

    // Snapshot, last-emitted frame and statistics counters
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_r        <= '0;
            last_frame_r  <= '0;
            frame_count_r <= '0;
            drop_count_r  <= 8'd0;
        end else begin
            if (accept_s) begin
                snap_r <= display;
            end else if (xfer_s) begin
                snap_r <= snap_rot_s;
            end
            if (finish_s) begin
                last_frame_r  <= snap_rot_s;
                frame_count_r <= frame_count_r + CNT_W'(1);
            end
            if (drop_s && (drop_count_r != 8'hFF)) begin
                drop_count_r <= drop_count_r + 8'd1;
            end
        end
    end

    display_beat_counter #(
        .TOTAL (TOTAL),
        .BPR   (BPR),
        .IDX_W (IDX_W)
    ) u_beat_counter (
        .clk           (clk),
        .reset         (reset),
        .load          (accept_s),
        .advance       (xfer_s),
        .first_beat    (first_beat_s),
        .last_of_row   (last_of_row_s),
        .last_of_frame (last_of_frame_s)
    );

    assign busy        = (state_r == ST_STREAM);
    assign out_valid   = busy;
    assign out_data    = snap_r[PIX_N-1 -: BEAT_W];
    assign out_sof     = busy & first_beat_s;
    assign out_eol     = busy & last_of_row_s;
    assign out_eof     = busy & last_of_frame_s;
    assign frame_count = frame_count_r;
    assign drop_count  = drop_count_r;

endmodule

// File: tb/tb_display_frame_streamer.sv
// Randomized self-checking bench for display_frame_streamer against a pixel-level reference model.
module tb_display_frame_streamer;

    localparam int DW    = 64;
    localparam int DH    = 32;
    localparam int BW    = 8;
    localparam int CW    = 16;
    localparam int N     = DW * DH;
    localparam int BPR   = DW / BW;
    localparam int TOTAL = N / BW;

    typedef struct packed {
        logic [BW-1:0] data;
        logic          sof;
        logic          eol;
        logic          eof;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  display;
    logic          frame_tick;
    logic          change_only;
    logic          out_ready;
    logic          out_valid;
    logic [BW-1:0] out_data;
    logic          out_sof;
    logic          out_eol;
    logic          out_eof;
    logic          busy;
    logic [CW-1:0] frame_count;
    logic [7:0]    drop_count;

    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] ref_last;
    int           ref_frames;
    int           ref_drops;

    display_frame_streamer #(
        .DISP_W (DW),
        .DISP_H (DH),
        .BEAT_W (BW),
        .CNT_W  (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .display     (display),
        .frame_tick  (frame_tick),
        .change_only (change_only),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_sof     (out_sof),
        .out_eol     (out_eol),
        .out_eof     (out_eof),
        .busy        (busy),
        .frame_count (frame_count),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    // Reference: beat k holds pixels k*BW .. k*BW+BW-1, lowest pixel in the MSB
    function automatic beat_t exp_beat(input logic [N-1:0] f, input int k);
        beat_t r;
        for (int i = 0; i < BW; i++) begin
            r.data[BW-1-i] = f[N-1-(k*BW+i)];
        end
        r.sof = (k == 0);
        r.eol = (((k + 1) % BPR) == 0);
        r.eof = (k == TOTAL - 1);
        return r;
    endfunction

    function automatic logic [N-1:0] rand_frame();
        logic [N-1:0] v;
        for (int i = 0; i < N / 32; i++) begin
            v[i*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        frame_tick = 1'b0;
        out_ready  = 1'b0;
        step();
        step();
        reset      = 1'b0;
        ref_frames = 0;
        ref_drops  = 0;
        ref_last   = '0;
    endtask

    task automatic test_reset();
        display     = rand_frame();
        change_only = 1'b0;
        frame_tick  = 1'b1;
        reset       = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b busy=%b, want 0 0", out_valid, busy);
        end
        checks++;
        if ({out_sof, out_eol, out_eof} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: sof/eol/eof=%b, want 000", {out_sof, out_eol, out_eof});
        end
        checks++;
        if (frame_count !== 16'd0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_counts: frames=%0d drops=%0d, want 0 0", frame_count, drop_count);
        end
        frame_tick = 1'b0;
        reset      = 1'b0;
        ref_frames = 0;
        ref_drops  = 0;
        ref_last   = '0;
        step();
    endtask

    task automatic test_single_pixel();
        logic [N-1:0] f;
        beat_t        e;
        beat_t        obs;
        int           eols;
        int           eofs;
        f          = '0;
        f[N-1]     = 1'b1;
        display    = f;
        out_ready  = 1'b1;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h80 || out_sof !== 1'b1) begin
            errors++;
            $display("FAIL first_beat: valid=%b data=%h sof=%b, want 1 80 1", out_valid, out_data, out_sof);
        end
        eols = 0;
        eofs = 0;
        for (int k = 0; k < TOTAL; k++) begin
            e   = exp_beat(f, k);
            obs = {out_data, out_sof, out_eol, out_eof};
            checks++;
            if (out_valid !== 1'b1 || obs !== e) begin
                errors++;
                $display("FAIL single_beat %0d: valid=%b got=%h want=%h", k, out_valid, obs, e);
            end
            eols += int'(out_eol);
            eofs += int'(out_eof);
            step();
        end
        ref_frames++;
        ref_last = f;
        checks++;
        if (eols != DH || eofs != 1) begin
            errors++;
            $display("FAIL flag_counts: eol=%0d eof=%0d, want %0d 1", eols, eofs, DH);
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || frame_count !== CW'(ref_frames)) begin
            errors++;
            $display("FAIL single_end: valid=%b busy=%b frames=%0d, want 0 0 %0d",
                     out_valid, busy, frame_count, ref_frames);
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] f;
        beat_t        e;
        beat_t        obs;
        beat_t        held;
        int           k;
        int           stall;
        int           cyc;
        f          = rand_frame();
        display    = f;
        frame_tick = 1'b1;
        out_ready  = 1'b1;
        step();
        frame_tick = 1'b0;
        k     = 0;
        stall = 0;
        cyc   = 0;
        held  = '0;
        while (k < TOTAL && cyc < 3000) begin
            e   = exp_beat(f, k);
            obs = {out_data, out_sof, out_eol, out_eof};
            checks++;
            if (out_valid !== 1'b1 || obs !== e) begin
                errors++;
                $display("FAIL bp_beat %0d: valid=%b got=%h want=%h", k, out_valid, obs, e);
            end
            if (k == 3 && stall < 5) begin
                if (stall == 0) begin
                    held = obs;
                end else begin
                    checks++;
                    if (obs !== held) begin
                        errors++;
                        $display("FAIL bp_hold: got=%h want=%h", obs, held);
                    end
                end
                stall++;
                out_ready = 1'b0;
            end else begin
                out_ready = 1'b1;
                k++;
            end
            step();
            cyc++;
        end
        ref_frames++;
        ref_last = f;
        checks++;
        if (k != TOTAL || cyc != TOTAL + 5) begin
            errors++;
            $display("FAIL bp_length: beats=%0d cycles=%0d, want %0d %0d", k, cyc, TOTAL, TOTAL + 5);
        end
        checks++;
        if (out_valid !== 1'b0 || frame_count !== CW'(ref_frames)) begin
            errors++;
            $display("FAIL bp_end: valid=%b frames=%0d, want 0 %0d", out_valid, frame_count, ref_frames);
        end
    endtask

    task automatic test_drop_isolation();
        logic [N-1:0] f;
        beat_t        e;
        beat_t        obs;
        apply_reset();
        f          = rand_frame();
        display    = f;
        frame_tick = 1'b1;
        out_ready  = 1'b1;
        step();
        frame_tick = 1'b0;
        for (int k = 0; k < TOTAL; k++) begin
            e   = exp_beat(f, k);
            obs = {out_data, out_sof, out_eol, out_eof};
            checks++;
            if (out_valid !== 1'b1 || obs !== e) begin
                errors++;
                $display("FAIL iso_beat %0d: valid=%b got=%h want=%h", k, out_valid, obs, e);
            end
            frame_tick = (k == 10) || (k == TOTAL - 1);
            if (k % 37 == 5) begin
                display = rand_frame();
            end
            step();
        end
        frame_tick = 1'b0;
        ref_drops  = 2;
        ref_frames++;
        ref_last = f;
        checks++;
        if (drop_count !== 8'(ref_drops) || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_count: drops=%0d valid=%b, want %0d 0", drop_count, out_valid, ref_drops);
        end
        checks++;
        if (frame_count !== CW'(ref_frames)) begin
            errors++;
            $display("FAIL iso_frames: frames=%0d, want %0d", frame_count, ref_frames);
        end
    endtask

    task automatic test_drop_saturation();
        logic [N-1:0] f;
        beat_t        e;
        beat_t        obs;
        int           k;
        int           cyc;
        f          = rand_frame();
        display    = f;
        frame_tick = 1'b1;
        out_ready  = 1'b0;
        step();
        k   = 0;
        cyc = 0;
        while (k < TOTAL && cyc < 3000) begin
            e   = exp_beat(f, k);
            obs = {out_data, out_sof, out_eol, out_eof};
            checks++;
            if (out_valid !== 1'b1 || obs !== e) begin
                errors++;
                $display("FAIL sat_beat %0d: valid=%b got=%h want=%h", k, out_valid, obs, e);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_ready) begin
                k++;
            end
            step();
            cyc++;
        end
        frame_tick = 1'b0;
        ref_drops  = (ref_drops + cyc > 255) ? 255 : ref_drops + cyc;
        ref_frames++;
        ref_last = f;
        checks++;
        if (k != TOTAL || drop_count !== 8'(ref_drops)) begin
            errors++;
            $display("FAIL drop_sat: beats=%0d drops=%0d, want %0d %0d", k, drop_count, TOTAL, ref_drops);
        end
        checks++;
        if (out_valid !== 1'b0 || frame_count !== CW'(ref_frames)) begin
            errors++;
            $display("FAIL sat_end: valid=%b frames=%0d, want 0 %0d", out_valid, frame_count, ref_frames);
        end
    endtask

    task automatic test_change_only();
        logic [N-1:0] f;
        beat_t        e;
        beat_t        obs;
        int           k;
        int           cyc;
        apply_reset();
        change_only = 1'b1;
        display     = '0;
        frame_tick  = 1'b1;
        out_ready   = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || frame_count !== 16'd0) begin
            errors++;
            $display("FAIL co_zero_skip: valid=%b busy=%b frames=%0d, want 0 0 0", out_valid, busy, frame_count);
        end
        f          = '0;
        f[N-1-5]   = 1'b1;
        display    = f;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        k   = 0;
        cyc = 0;
        while (k < TOTAL && cyc < 3000) begin
            e   = exp_beat(f, k);
            obs = {out_data, out_sof, out_eol, out_eof};
            checks++;
            if (out_valid !== 1'b1 || obs !== e) begin
                errors++;
                $display("FAIL co_beat %0d: valid=%b got=%h want=%h", k, out_valid, obs, e);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_ready) begin
                k++;
            end
            step();
            cyc++;
        end
        ref_frames++;
        ref_last = f;
        checks++;
        if (k != TOTAL || frame_count !== CW'(ref_frames)) begin
            errors++;
            $display("FAIL co_frame: beats=%0d frames=%0d, want %0d %0d", k, frame_count, TOTAL, ref_frames);
        end
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || frame_count !== CW'(ref_frames)) begin
            errors++;
            $display("FAIL co_repeat_skip: valid=%b frames=%0d, want 0 %0d", out_valid, frame_count, ref_frames);
        end
        change_only = 1'b0;
    endtask

    task automatic test_reset_mid_stream();
        logic [N-1:0] f;
        beat_t        e;
        beat_t        obs;
        apply_reset();
        display    = rand_frame();
        frame_tick = 1'b1;
        out_ready  = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (100) step();
        reset      = 1'b1;
        frame_tick = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || {out_sof, out_eol, out_eof} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_ctrl: valid=%b busy=%b flags=%b, want 0 0 000",
                     out_valid, busy, {out_sof, out_eol, out_eof});
        end
        checks++;
        if (frame_count !== 16'd0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL midreset_counts: frames=%0d drops=%0d, want 0 0", frame_count, drop_count);
        end
        reset      = 1'b0;
        frame_tick = 1'b0;
        ref_frames = 0;
        ref_drops  = 0;
        ref_last   = '0;
        step();
        f          = rand_frame();
        display    = f;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        for (int k = 0; k < TOTAL; k++) begin
            e   = exp_beat(f, k);
            obs = {out_data, out_sof, out_eol, out_eof};
            checks++;
            if (out_valid !== 1'b1 || obs !== e) begin
                errors++;
                $display("FAIL restart_beat %0d: valid=%b got=%h want=%h", k, out_valid, obs, e);
            end
            step();
        end
        ref_frames++;
        ref_last = f;
        checks++;
        if (out_valid !== 1'b0 || frame_count !== CW'(ref_frames)) begin
            errors++;
            $display("FAIL restart_end: valid=%b frames=%0d, want 0 %0d", out_valid, frame_count, ref_frames);
        end
    endtask

    task automatic test_random_frames();
        logic [N-1:0] f;
        beat_t        e;
        beat_t        obs;
        logic         take;
        int           k;
        int           cyc;
        for (int n = 0; n < 8; n++) begin
            f           = ($urandom_range(0, 2) == 0) ? ref_last : rand_frame();
            change_only = ($urandom_range(0, 1) == 1);
            take        = !(change_only && (f == ref_last));
            display     = f;
            frame_tick  = 1'b1;
            out_ready   = 1'b0;
            step();
            frame_tick = 1'b0;
            k   = 0;
            cyc = 0;
            if (take) begin
                while (k < TOTAL && cyc < 3000) begin
                    e   = exp_beat(f, k);
                    obs = {out_data, out_sof, out_eol, out_eof};
                    checks++;
                    if (out_valid !== 1'b1 || obs !== e) begin
                        errors++;
                        $display("FAIL rand_beat f%0d b%0d: valid=%b got=%h want=%h", n, k, out_valid, obs, e);
                    end
                    display   = rand_frame();
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_ready) begin
                        k++;
                    end
                    step();
                    cyc++;
                end
                ref_frames++;
                ref_last = f;
            end
            checks++;
            if (out_valid !== 1'b0 || frame_count !== CW'(ref_frames)) begin
                errors++;
                $display("FAIL rand_frame %0d: valid=%b frames=%0d, want 0 %0d", n, out_valid, frame_count, ref_frames);
            end
        end
        change_only = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        display     = '0;
        frame_tick  = 1'b0;
        change_only = 1'b0;
        out_ready   = 1'b0;
        ref_last    = '0;
        ref_frames  = 0;
        ref_drops   = 0;
        test_reset();
        test_single_pixel();
        test_backpressure();
        test_drop_isolation();
        test_drop_saturation();
        test_change_only();
        test_reset_mid_stream();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
